// File: rtl/dac_output_ramp.sv
// rtl/dac_output_ramp.sv - DAC output stage with slew-limited engage/disengage ramps
// Optional rail-stuck monitor enabled by defining RAIL_MONITOR_EN.
module dac_output_ramp #(
  parameter int RAIL_THRESHOLD = 65535
) (
  input  logic               clock,
  input  logic               reset,
  input  logic signed [13:0] controlSignalIn,
  input  logic signed [13:0] offsetIn,
  input  logic signed [13:0] parkValueIn,
  input  logic               enableIn,
  input  logic [7:0]         maxStepIn,
  input  logic [15:0]        tickDivIn,
  output logic signed [13:0] dacOut,
  output logic [1:0]         stateOut,
  output logic               atGoalOut,
  output logic               railAlarmOut
);

  typedef enum logic [1:0] {
    PARKED   = 2'd0,
    RAMP_IN  = 2'd1,
    TRACK    = 2'd2,
    RAMP_OUT = 2'd3
  } state_t;

  localparam logic signed [13:0] RAIL_HIGH = 14'sh1FFF;
  localparam logic signed [13:0] RAIL_LOW  = 14'sh2000;

  state_t             state, state_next;
  logic signed [13:0] target, target_next;
  logic signed [13:0] goal, dac_next, step_value;
  logic [14:0]        sum, diff, magnitude, moved, dac_wide, step_wide;
  logic [15:0]        tick_count;
  logic               tick, advance, at_goal;

  // Offset sum is formed one bit wider so the clamp sees the true overflow.
  always_comb begin
    sum = {controlSignalIn[13], controlSignalIn} + {offsetIn[13], offsetIn};
    if (sum[14] != sum[13]) begin
      target_next = sum[14] ? RAIL_LOW : RAIL_HIGH;
    end else begin
      target_next = $signed(sum[13:0]);
    end
  end

  // A compare rather than an equality lets a lowered divider tick at once.
  assign tick    = (tick_count >= tickDivIn);
  assign advance = tick || (maxStepIn == 8'd0);

  always_comb begin
    goal = ((state == PARKED) || (state == RAMP_OUT)) ? parkValueIn : target;
  end

  assign at_goal   = (dacOut == goal);
  assign atGoalOut = at_goal;
  assign stateOut  = state;

  always_comb begin
    dac_wide  = {dacOut[13], dacOut};
    step_wide = {7'd0, maxStepIn};
    diff      = {goal[13], goal} - dac_wide;
    magnitude = diff[14] ? (15'd0 - diff) : diff;
    moved     = diff[14] ? (dac_wide - step_wide) : (dac_wide + step_wide);
    if ((magnitude <= step_wide) || (maxStepIn == 8'd0)) begin
      step_value = goal;
    end else begin
      step_value = $signed(moved[13:0]);
    end
  end

  // Enable changes are checked before goal arrival so they always win.
  always_comb begin
    state_next = state;
    dac_next   = dacOut;
    case (state)
      PARKED: begin
        dac_next = parkValueIn;
        if (enableIn) state_next = RAMP_IN;
      end
      RAMP_IN: begin
        if (!enableIn)     state_next = RAMP_OUT;
        else if (at_goal)  state_next = TRACK;
        else if (advance)  dac_next   = step_value;
      end
      TRACK: begin
        dac_next = target;
        if (!enableIn) state_next = RAMP_OUT;
      end
      RAMP_OUT: begin
        if (enableIn)      state_next = RAMP_IN;
        else if (at_goal)  state_next = PARKED;
        else if (advance)  dac_next   = step_value;
      end
      default: state_next = PARKED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= PARKED;
      dacOut     <= 14'sd0;
      target     <= 14'sd0;
      tick_count <= 16'd0;
    end else begin
      state      <= state_next;
      dacOut     <= dac_next;
      target     <= target_next;
      tick_count <= tick ? 16'd0 : (tick_count + 16'd1);
    end
  end

`ifdef RAIL_MONITOR_EN
  localparam logic [15:0] RAIL_LIMIT = 16'(RAIL_THRESHOLD);

  logic [15:0] rail_count;
  logic        at_rail;

  assign at_rail = (state == TRACK) && ((target == RAIL_HIGH) || (target == RAIL_LOW));

  always_ff @(posedge clock) begin
    if (reset) begin
      rail_count <= 16'd0;
    end else if (!at_rail) begin
      rail_count <= 16'd0;
    end else if (rail_count != RAIL_LIMIT) begin
      rail_count <= rail_count + 16'd1;
    end
  end

  assign railAlarmOut = (rail_count == RAIL_LIMIT);
`else
  // Constant 0 for every legal threshold; the parameter stays referenced.
  assign railAlarmOut = (RAIL_THRESHOLD < 1);
`endif

endmodule

// File: tb/tb_dac_output_ramp.sv
// tb/tb_dac_output_ramp.sv - scoreboard bench for dac_output_ramp
module tb_dac_output_ramp;

  logic               clock = 1'b0;
  logic               reset;
  logic signed [13:0] cs, off, park;
  logic               en;
  logic [7:0]         ms;
  logic [15:0]        td;
  logic signed [13:0] dac;
  logic [1:0]         st;
  logic               atg, rail;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam int NA = -100000;
`ifdef RAIL_MONITOR_EN
  localparam logic RAIL_ON = 1'b1;
`else
  localparam logic RAIL_ON = 1'b0;
`endif

  typedef struct {
    int    due;
    string name;
    int    dac;
    int    st;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  dac_output_ramp #(.RAIL_THRESHOLD(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .controlSignalIn (cs),
    .offsetIn        (off),
    .parkValueIn     (park),
    .enableIn        (en),
    .maxStepIn       (ms),
    .tickDivIn       (td),
    .dacOut          (dac),
    .stateOut        (st),
    .atGoalOut       (atg),
    .railAlarmOut    (rail)
  );

  function automatic int sat14(int v);
    if (v > 8191)  return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  task automatic push(int due, string name, int d, int s);
    exp_t e;
    e.due = due; e.name = name; e.dac = d; e.st = s;
    sb.push_back(e);
  endtask

  // Advance one clock, then retire every scoreboard entry due this cycle.
  task automatic clk_step();
    int i;
    @(posedge clock);
    #1;
    cyc++;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        if (sb[i].dac != NA) begin
          checks++;
          if (int'(dac) !== sb[i].dac) begin
            errors++;
            $display("FAIL %s cycle %0d: dacOut=%0d expected %0d", sb[i].name, cyc, dac, sb[i].dac);
          end
        end
        if (sb[i].st != NA) begin
          checks++;
          if (int'(st) !== sb[i].st) begin
            errors++;
            $display("FAIL %s cycle %0d: stateOut=%0d expected %0d", sb[i].name, cyc, st, sb[i].st);
          end
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) clk_step();
  endtask

  task automatic test_reset();
    reset = 1'b1; cs = 14'sd0; off = 14'sd0; park = 14'sd0;
    en = 1'b1; ms = 8'd100; td = 16'd3;
    steps(2);
    checks++; if (dac !== 14'sd0) begin errors++; $display("FAIL reset_dac: dacOut=%0d expected 0", dac); end
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_state: stateOut=%0d expected 0", st); end
    checks++; if (rail !== 1'b0) begin errors++; $display("FAIL reset_rail: railAlarmOut=%0b expected 0", rail); end
    checks++; if (atg !== 1'b1) begin errors++; $display("FAIL reset_atgoal: atGoalOut=%0b expected 1", atg); end
    park = 14'sd123;
    clk_step();
    checks++; if (dac !== 14'sd0) begin errors++; $display("FAIL reset_override: dacOut=%0d expected 0", dac); end
    reset = 1'b0; en = 1'b0;
    push(cyc + 1, "park_after_reset", 123, 0);
    clk_step();
  endtask

  task automatic test_ramp_in();
    int n, c;
    reset = 1'b1; park = 14'sd0; cs = 14'sd1000; off = 14'sd0;
    ms = 8'd100; td = 16'd3; en = 1'b0;
    clk_step();
    reset = 1'b0; en = 1'b1;
    n = 0;
    while (dac == 14'sd0 && n < 12) begin clk_step(); n++; end
    checks++; if (dac !== 14'sd100) begin errors++; $display("FAIL ramp_in_first: dacOut=%0d expected 100", dac); end
    c = cyc;
    for (int k = 1; k <= 36; k++) push(c + k, "ramp_in", 100 * (1 + k / 4), 1);
    push(c + 37, "ramp_in_track", 1000, 2);
    steps(37);
    checks++; if (atg !== 1'b1) begin errors++; $display("FAIL ramp_in_atgoal: atGoalOut=%0b expected 1", atg); end
  endtask

  task automatic test_track_back_to_back();
    int v;
    for (int i = 0; i < 12; i++) begin
      if (i == 0)      begin cs = 14'sd8000;  off = 14'sd500;  end
      else if (i == 1) begin cs = -14'sd8000; off = -14'sd500; end
      else             begin cs = 14'($urandom()); off = 14'($urandom()); end
      v = sat14(int'(cs) + int'(off));
      push(cyc + 2, (i < 2) ? "track_saturate" : "track_b2b", v, 2);
      clk_step();
    end
    steps(2);
  endtask

  task automatic test_ramp_out();
    int n, c;
    cs = 14'sd250; off = 14'sd0;
    steps(3);
    checks++; if (dac !== 14'sd250) begin errors++; $display("FAIL ramp_out_start: dacOut=%0d expected 250", dac); end
    park = 14'sd0; ms = 8'd100; td = 16'd3; en = 1'b0;
    clk_step();
    checks++; if (st !== 2'd3) begin errors++; $display("FAIL ramp_out_enter: stateOut=%0d expected 3", st); end
    n = 0;
    while (dac == 14'sd250 && n < 8) begin clk_step(); n++; end
    checks++; if (dac !== 14'sd150) begin errors++; $display("FAIL ramp_out_first: dacOut=%0d expected 150", dac); end
    c = cyc;
    push(c + 4, "ramp_out", 50, 3);
    push(c + 8, "ramp_out", 0, 3);
    push(c + 9, "ramp_out_parked", 0, 0);
    steps(9);
    checks++; if (atg !== 1'b1) begin errors++; $display("FAIL ramp_out_atgoal: atGoalOut=%0b expected 1", atg); end
  endtask

  task automatic test_priority();
    cs = 14'sd0;
    steps(2);
    en = 1'b1;
    clk_step();
    checks++; if (st !== 2'd1) begin errors++; $display("FAIL prio_enter: stateOut=%0d expected 1", st); end
    checks++; if (atg !== 1'b1) begin errors++; $display("FAIL prio_atgoal: atGoalOut=%0b expected 1", atg); end
    en = 1'b0;
    clk_step();
    checks++; if (st !== 2'd3) begin errors++; $display("FAIL prio_enable_wins: stateOut=%0d expected 3", st); end
    clk_step();
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL prio_parked: stateOut=%0d expected 0", st); end
  endtask

  task automatic test_reversal();
    int n, c;
    cs = 14'sd500; ms = 8'd0; en = 1'b1;
    steps(4);
    checks++; if (st !== 2'd2 || dac !== 14'sd500) begin errors++; $display("FAIL rev_track: stateOut=%0d dacOut=%0d expected 2/500", st, dac); end
    ms = 8'd100; td = 16'd3; en = 1'b0;
    clk_step();
    checks++; if (st !== 2'd3 || dac !== 14'sd500) begin errors++; $display("FAIL rev_rampout: stateOut=%0d dacOut=%0d expected 3/500", st, dac); end
    cs = 14'sd800; en = 1'b1;
    clk_step();
    checks++; if (st !== 2'd1 || dac !== 14'sd500) begin errors++; $display("FAIL rev_rampin: stateOut=%0d dacOut=%0d expected 1/500", st, dac); end
    n = 0;
    while (dac == 14'sd500 && n < 8) begin clk_step(); n++; end
    checks++; if (dac !== 14'sd600) begin errors++; $display("FAIL rev_first_step: dacOut=%0d expected 600", dac); end
    c = cyc;
    push(c + 4, "reversal", 700, 1);
    push(c + 8, "reversal", 800, 1);
    push(c + 9, "reversal_track", 800, 2);
    steps(9);
  endtask

  task automatic test_max_step_zero();
    td = 16'd60000; ms = 8'd0; park = -14'sd300; en = 1'b0;
    push(cyc + 1, "step0_out", 800, 3);
    push(cyc + 2, "step0_out", -300, 3);
    push(cyc + 3, "step0_parked", -300, 0);
    steps(3);
    cs = 14'sd3000; en = 1'b1;
    push(cyc + 1, "step0_in", -300, 1);
    push(cyc + 2, "step0_in", 3000, 1);
    push(cyc + 3, "step0_track", 3000, 2);
    steps(3);
  endtask

  task automatic test_tick_lower_redirect();
    int n0;
    ms = 8'd0; park = 14'sd0; en = 1'b0;
    steps(3);
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL tick_setup: stateOut=%0d expected 0", st); end
    cs = 14'sd1000; ms = 8'd100; en = 1'b1;
    clk_step();
    for (int k = 1; k <= 20; k++) push(cyc + k, "slow_tick_hold", 0, 1);
    steps(20);
    td = 16'd2;
    n0 = cyc;
    push(n0 + 1, "tick_lowered", 100, 1);
    push(n0 + 2, "tick_lowered", 100, 1);
    push(n0 + 3, "tick_lowered", 100, 1);
    push(n0 + 4, "tick_lowered", 200, 1);
    steps(4);
    cs = 14'sd250;
    push(n0 + 5, "redirect", 200, 1);
    push(n0 + 6, "redirect", 200, 1);
    push(n0 + 7, "redirect", 250, 1);
    push(n0 + 8, "redirect_track", 250, 2);
    steps(4);
  endtask

  task automatic test_reset_mid_ramp();
    park = 14'sd77; ms = 8'd0; en = 1'b0;
    steps(3);
    ms = 8'd10; td = 16'd0; cs = 14'sd1000; en = 1'b1;
    steps(3);
    checks++; if (st !== 2'd1 || dac !== 14'sd97) begin errors++; $display("FAIL midramp_setup: stateOut=%0d dacOut=%0d expected 1/97", st, dac); end
    reset = 1'b1;
    clk_step();
    checks++; if (st !== 2'd0 || dac !== 14'sd0) begin errors++; $display("FAIL midramp_reset: stateOut=%0d dacOut=%0d expected 0/0", st, dac); end
    reset = 1'b0; en = 1'b0;
    clk_step();
    checks++; if (dac !== 14'sd77) begin errors++; $display("FAIL midramp_release: dacOut=%0d expected 77", dac); end
  endtask

  task automatic test_rail();
    reset = 1'b1;
    clk_step();
    reset = 1'b0; cs = 14'sd100; off = 14'sd0; park = 14'sd0; ms = 8'd0; en = 1'b1;
    steps(4);
    checks++; if (st !== 2'd2 || rail !== 1'b0) begin errors++; $display("FAIL rail_setup: stateOut=%0d railAlarmOut=%0b expected 2/0", st, rail); end
    cs = 14'sd8191;
    push(cyc + 2, "rail_dac", 8191, 2);
    for (int k = 1; k <= 12; k++) begin
      clk_step();
      if (k == 8) begin
        checks++; if (rail !== 1'b0) begin errors++; $display("FAIL rail_early: railAlarmOut=%0b expected 0", rail); end
      end
      if (k == 9 || k == 12) begin
        checks++; if (rail !== RAIL_ON) begin errors++; $display("FAIL rail_raise: railAlarmOut=%0b expected %0b", rail, RAIL_ON); end
      end
    end
    cs = 14'sd8190;
    clk_step();
    checks++; if (rail !== RAIL_ON) begin errors++; $display("FAIL rail_hold: railAlarmOut=%0b expected %0b", rail, RAIL_ON); end
    clk_step();
    checks++; if (rail !== 1'b0) begin errors++; $display("FAIL rail_clear: railAlarmOut=%0b expected 0", rail); end
  endtask

  initial begin
    test_reset();
    test_ramp_in();
    test_track_back_to_back();
    test_ramp_out();
    test_priority();
    test_reversal();
    test_max_step_zero();
    test_tick_lower_redirect();
    test_reset_mid_ramp();
    test_rail();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_output_ramp.md
DAC_OUTPUT_RAMP -- requirements
Module: dac_output_ramp

Interface
REQ-001 Parameter RAIL_THRESHOLD, default 65535: consecutive in-rail TRACK cycles needed to raise railAlarmOut; range 1..65535.
REQ-002 clock  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 controlSignalIn  input  14 signed  control word from the upstream I-feedback stage.
REQ-005 offsetIn  input  14 signed  static DAC offset added to controlSignalIn.
REQ-006 parkValueIn  input  14 signed  output value while disengaged.
REQ-007 enableIn  input  1  1 = engage loop output, 0 = disengage.
REQ-008 maxStepIn  input  8 unsigned  maximum dacOut change per ramp tick.
REQ-009 tickDivIn  input  16 unsigned  ramp tick period minus one, in clocks.
REQ-010 dacOut  output  14 signed  registered DAC code.
REQ-011 stateOut  output  2  current state encoding.
REQ-012 atGoalOut  output  1  dacOut equals the current goal.
REQ-013 railAlarmOut  output  1  output stuck at a rail.

Function
REQ-014 target SHALL be registered each cycle as controlSignalIn + offsetIn computed in 15 bits, saturated to [-8192, 8191].
REQ-015 Tick counter SHALL count 0..tickDivIn, pulse tick for one cycle when count >= tickDivIn, then reload 0; tickDivIn=0 gives a tick every cycle.
REQ-016 tickDivIn lowered below the current count SHALL produce a tick on the next cycle, with no wrap through 65535.
REQ-017 States: PARKED=0, RAMP_IN=1, TRACK=2, RAMP_OUT=3.
REQ-018 PARKED: goal = parkValueIn; dacOut <= parkValueIn each cycle; enableIn=1 -> RAMP_IN.
REQ-019 RAMP_IN: goal = target; on tick dacOut steps toward goal; dacOut==goal -> TRACK; enableIn=0 -> RAMP_OUT from the current dacOut.
REQ-020 TRACK: goal = target; dacOut <= target every cycle (latency controlSignalIn -> dacOut = 2 clocks); enableIn=0 -> RAMP_OUT.
REQ-021 RAMP_OUT: goal = parkValueIn; on tick dacOut steps toward goal; dacOut==goal -> PARKED; enableIn=1 -> RAMP_IN from the current dacOut.
REQ-022 Step rule: diff = goal - dacOut in 15 bits; |diff| <= maxStepIn -> dacOut = goal exactly; else dacOut moves by maxStepIn toward goal; no overshoot, no wrap.
REQ-023 maxStepIn=0 SHALL make ramps complete on the next cycle, regardless of tick.
REQ-024 Goal change mid-ramp SHALL redirect the ramp on the next tick without restarting the tick counter.
REQ-025 Goal reached and enableIn toggled in the same cycle: the enableIn transition SHALL take priority.
REQ-026 atGoalOut SHALL be combinational (dacOut == goal).

Reset
REQ-027 Reset SHALL set state=PARKED, dacOut=0, target=0, tick counter=0, rail counter=0, railAlarmOut=0.
REQ-028 Reset SHALL override all inputs on the cycle it is sampled, including mid-ramp.
REQ-029 After reset deasserts, dacOut SHALL equal parkValueIn one cycle later.

Configuration
REQ-030 With RAIL_MONITOR_EN defined: a 16-bit counter SHALL increment each TRACK cycle in which target is 8191 or -8192, saturating at RAIL_THRESHOLD.
REQ-031 With RAIL_MONITOR_EN defined: the counter SHALL clear on any other cycle, and railAlarmOut SHALL be 1 while counter == RAIL_THRESHOLD.
REQ-032 Without RAIL_MONITOR_EN: railAlarmOut SHALL be tied to 0 and no counter logic is synthesized.

Verification
REQ-033 Ramp in: reset, parkValueIn=0, controlSignalIn=1000, offsetIn=0, maxStepIn=100, tickDivIn=3, enableIn=1 -> dacOut rises by 100 every 4 clocks, reaches 1000 after 10 ticks, stateOut=2.
REQ-034 Saturation: in TRACK, controlSignalIn=8000, offsetIn=500 -> dacOut=8191 two clocks later; controlSignalIn=-8000, offsetIn=-500 -> dacOut=-8192.
REQ-035 Ramp out with remainder: in TRACK at dacOut=250, parkValueIn=0, maxStepIn=100, enableIn=0 -> dacOut 150, 50, 0 on successive ticks, then stateOut=0 and atGoalOut=1.
REQ-036 Reversal: during RAMP_OUT at dacOut=500, enableIn=1 with target=800 -> stateOut=1, dacOut climbs from 500 with no jump.
REQ-037 Reset mid-ramp: assert reset during RAMP_IN -> next cycle dacOut=0 and stateOut=0; after release, dacOut=parkValueIn.
REQ-038 Rail alarm (RAIL_MONITOR_EN, RAIL_THRESHOLD=8): target held at 8191 in TRACK -> railAlarmOut=1 after 8 cycles; target=8190 -> railAlarmOut=0 next cycle.
